// File: rtl/wb_uart16550_rx_mon_if.sv
// Receive-byte stream between the UART RX monitor and its consumer.
`timescale 1ns/1ps
interface wb_uart16550_rx_mon_if;
  logic [7:0] dat_o;
  logic       err_o;
  logic       valid_o;
  logic       ready_i;

  modport master (output dat_o, output err_o, output valid_o, input ready_i);
  modport slave  (input dat_o, input err_o, input valid_o, output ready_i);
endinterface

// File: rtl/wb_uart16550_rx_mon.sv
// 16x-oversampling UART receiver feeding a small byte FIFO with sticky overflow.
// Optional parity stage enabled by defining WB_UART16550_RX_MON_PARITY_EN.
`timescale 1ns/1ps
module wb_uart16550_rx_mon #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          rx_i,
  input  logic [15:0]                   divisor_i,
  input  logic                          parity_odd_i,
  output logic                          ovf_o,
  input  logic                          ovf_clr_i,
  wb_uart16550_rx_mon_if.master         rxq
);

  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

`ifdef WB_UART16550_RX_MON_PARITY_EN
  // Parity bit the transmitter should have sent for this byte.
  function automatic logic par_exp_f(input logic [7:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic unused_par_s;
  assign unused_par_s = parity_odd_i;
`endif

  logic        sync1_r, sync2_r, prev_r;
  logic        rx_s, fall_s;
  logic [15:0] div_cnt_r, div_m1_s;
  logic        tick_s, start_s;
  state_t      state_r, state_nxt_s;
  logic [3:0]  tcnt_r, tcnt_nxt_s;
  logic [2:0]  bcnt_r, bcnt_nxt_s;
  logic [7:0]  shreg_r, shreg_nxt_s;
  logic        perr_r, perr_nxt_s;
  logic        push_r, push_nxt_s;
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic [8:0]  mem_r [FIFO_DEPTH];
  logic        full_s, empty_s, pop_s, ovf_evt_s, ovf_r;

  assign rx_s     = sync2_r;
  assign fall_s   = prev_r & ~sync2_r;
  assign div_m1_s = (divisor_i == 16'd0) ? 16'd0 : (divisor_i - 16'd1);
  assign tick_s   = (div_cnt_r >= div_m1_s);

  // Line synchronizer and edge-detect history.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= rx_i;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  // Oversample tick divider, realigned to each start edge.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      div_cnt_r <= 16'd0;
    end else if (start_s || tick_s) begin
      div_cnt_r <= 16'd0;
    end else begin
      div_cnt_r <= div_cnt_r + 16'd1;
    end
  end

  // Frame FSM state and datapath registers.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_r <= ST_IDLE;
      tcnt_r  <= 4'd0;
      bcnt_r  <= 3'd0;
      shreg_r <= 8'd0;
      perr_r  <= 1'b0;
      push_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tcnt_r  <= tcnt_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      shreg_r <= shreg_nxt_s;
      perr_r  <= perr_nxt_s;
      push_r  <= push_nxt_s;
    end
  end

  // Frame FSM next-state: START decides at tick 8, later samples every 16 ticks.
  always_comb begin
    state_nxt_s = state_r;
    tcnt_nxt_s  = tcnt_r;
    bcnt_nxt_s  = bcnt_r;
    shreg_nxt_s = shreg_r;
    perr_nxt_s  = perr_r;
    push_nxt_s  = 1'b0;
    start_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (fall_s) begin
          state_nxt_s = ST_START;
          start_s     = 1'b1;
          tcnt_nxt_s  = 4'd0;
          bcnt_nxt_s  = 3'd0;
          perr_nxt_s  = 1'b0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (tick_s && (tcnt_r == 4'd7)) begin
          tcnt_nxt_s  = 4'd0;
          state_nxt_s = rx_s ? ST_IDLE : ST_DATA;
        end else if (tick_s) begin
          tcnt_nxt_s = tcnt_r + 4'd1;
        end else begin
          tcnt_nxt_s = tcnt_r;
        end
      end
      ST_DATA: begin
        if (tick_s && (tcnt_r == 4'd15)) begin
          tcnt_nxt_s  = 4'd0;
          shreg_nxt_s = {rx_s, shreg_r[7:1]};
          bcnt_nxt_s  = bcnt_r + 3'd1;
          if (bcnt_r == 3'd7) begin
`ifdef WB_UART16550_RX_MON_PARITY_EN
            state_nxt_s = ST_PARITY;
`else
            state_nxt_s = ST_STOP;
`endif
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else if (tick_s) begin
          tcnt_nxt_s = tcnt_r + 4'd1;
        end else begin
          tcnt_nxt_s = tcnt_r;
        end
      end
      ST_PARITY: begin
`ifdef WB_UART16550_RX_MON_PARITY_EN
        if (tick_s && (tcnt_r == 4'd15)) begin
          tcnt_nxt_s  = 4'd0;
          perr_nxt_s  = (rx_s != par_exp_f(shreg_r, parity_odd_i));
          state_nxt_s = ST_STOP;
        end else if (tick_s) begin
          tcnt_nxt_s = tcnt_r + 4'd1;
        end else begin
          tcnt_nxt_s = tcnt_r;
        end
`else
        state_nxt_s = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (tick_s && (tcnt_r == 4'd15)) begin
          tcnt_nxt_s  = 4'd0;
          perr_nxt_s  = perr_r | ~rx_s;
          push_nxt_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tick_s) begin
          tcnt_nxt_s = tcnt_r + 4'd1;
        end else begin
          tcnt_nxt_s = tcnt_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                     (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_s     = ~empty_s & rxq.ready_i;
  assign ovf_evt_s = push_r & full_s & ~pop_s;

  // Receive FIFO; a push into a full FIFO is dropped unless a pop frees the slot.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      ovf_r    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 9'd0;
      end
    end else begin
      if (push_r && (!full_s || pop_s)) begin
        mem_r[wr_ptr_r[AW-1:0]] <= {perr_r, shreg_r};
        wr_ptr_r                <= wr_ptr_r + (AW+1)'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + (AW+1)'(1);
      end
      if (ovf_evt_s) begin
        ovf_r <= 1'b1;
      end else if (ovf_clr_i) begin
        ovf_r <= 1'b0;
      end
    end
  end

  assign rxq.dat_o   = mem_r[rd_ptr_r[AW-1:0]][7:0];
  assign rxq.err_o   = mem_r[rd_ptr_r[AW-1:0]][8];
  assign rxq.valid_o = ~empty_s;
  assign ovf_o       = ovf_r;

endmodule

// File: doc/wb_uart16550_rx_mon.md
WB_UART16550_RX_MON -- requirements
Module: wb_uart16550_rx_mon

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, SHALL set the receive FIFO entry count; legal values are powers of two, 2..16.
REQ-002 clk_i  input  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-003 rstn_i  input  1  synchronous, active-low reset.
REQ-004 rx_i  input  1  asynchronous serial line from the UART stx_pad_o; idle level is 1.
REQ-005 divisor_i  input  16  divisor-latch value; bit period SHALL be 16*divisor_i clocks, and a value of 0 SHALL be treated as 1.
REQ-006 parity_odd_i  input  1  parity sense: 1 = odd, 0 = even; used only under REQ-024.
REQ-007 dat_o  output  8  received byte at the FIFO head.
REQ-008 err_o  output  1  framing/parity error flag of the FIFO-head byte.
REQ-009 valid_o  output  1  FIFO non-empty.
REQ-010 ready_i  input  1  consumer accept; a pop SHALL occur when valid_o && ready_i.
REQ-011 ovf_o  output  1  sticky overflow flag.
REQ-012 ovf_clr_i  input  1  clears ovf_o.

Function
REQ-013 rx_i SHALL pass through a 2-flop synchronizer; all decode uses the synchronized value.
REQ-014 A tick counter SHALL pulse once every divisor_i clocks (16x oversample tick); the counter SHALL reload when it reaches divisor_i-1, and SHALL reload on every FSM IDLE->START transition.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP; IDLE->START SHALL occur on the synchronized falling edge of rx.
REQ-016 START: on the 8th tick (mid-bit), line=1 SHALL return to IDLE with nothing pushed (glitch reject); line=0 SHALL move to DATA.
REQ-017 DATA: 8 bits SHALL be sampled LSB first, each on the 16th tick after the previous sample; after bit 7 the FSM SHALL go to PARITY (REQ-024) or STOP.
REQ-018 STOP: the sample taken 16 ticks later SHALL complete the frame; stop=0 SHALL set the frame's error bit; the FSM SHALL then return to IDLE, and in IDLE the next falling edge is the next start.
REQ-019 The byte and its error bit SHALL be pushed on the clock after the stop sample; valid_o SHALL rise on the following clock if the FIFO was empty.
REQ-020 The FIFO SHALL use wrapping read/write pointers of width log2(FIFO_DEPTH)+1. Full SHALL be defined as the MSBs differing with the low bits equal; empty SHALL be defined as the pointers being equal.
REQ-021 Push while full SHALL discard the new byte, leave the contents unchanged, and set ovf_o.
REQ-022 A simultaneous push and pop on a full FIFO SHALL succeed with no overflow; on an empty FIFO the push SHALL proceed and no pop SHALL occur.
REQ-023 ovf_clr_i coincident with an overflow event SHALL leave ovf_o=1 (set wins).

Configuration
REQ-024 Macro WB_UART16550_RX_MON_PARITY_EN defined: frame is 8 data + 1 parity + 1 stop; PARITY SHALL sample one bit 16 ticks after bit 7; a mismatch against parity_odd_i SHALL set the error bit. Undefined: PARITY is unreachable, frame is 8N1, and parity_odd_i is ignored.

Reset
REQ-025 With rstn_i=0, the FSM SHALL be IDLE, the synchronizer flops 1, pointers 0, and counters 0; the outputs SHALL be valid_o=0, err_o=0, ovf_o=0, dat_o=0.
REQ-026 Reset mid-frame SHALL abandon the frame with no push; the first falling edge after release SHALL start a new frame.

Verification
REQ-027 divisor_i=1, 8N1, send 0x55, ready_i=1 -> one beat dat_o=0x55, err_o=0, valid_o within 165 clocks of the start edge.
REQ-028 rx_i low for 4 clocks then high (divisor_i=1) -> no valid_o; a following 0xA3 frame -> dat_o=0xA3.
REQ-029 Send 0x0F with the stop bit driven 0 -> dat_o=0x0F, err_o=1.
REQ-030 ready_i=0, send 0x01..0x05 (FIFO_DEPTH=4) -> ovf_o=1, pops return 0x01..0x04; ovf_clr_i pulse -> ovf_o=0.
REQ-031 PARITY_EN, parity_odd_i=0, send 0x07 with parity bit 0 -> err_o=1; with parity bit 1 -> err_o=0.
REQ-032 Assert rstn_i at data bit 3 of 0x81, release, send 0x42 -> only 0x42 delivered.
